// File: rtl/fib_encoder.sv
// Greedy Zeckendorf (Fibonacci) encoder: 64-bit unsigned value in,
// 92-digit Fibonacci code out, one digit decided per clock from the top down.
module fib_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] din,
    output logic        busy,
    output logic        done,
    output logic [91:0] code,
    output logic [6:0]  ones
);

    // F(93) is the largest Fibonacci number below 2^64; F(92) is its predecessor.
    localparam logic [63:0] F93 = 64'd12200160415121876738;
    localparam logic [63:0] F92 = 64'd7540113804746346429;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [63:0] rem;   // value still to be represented
    logic [63:0] fhi;   // F(k) for the current step
    logic [63:0] flo;   // F(k-1), walks down with fhi
    logic [6:0]  k;     // current Fibonacci index, 93 down to 2

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state: start only matters in IDLE; the k=2 step closes the run
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (k == 7'd2) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs follow the registered state, so busy/done change on the same edges as it
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Datapath: load on acceptance, then one greedy subtraction test per RUN cycle.
    // No early exit when rem hits zero, so latency never depends on din.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem  <= '0;
            fhi  <= '0;
            flo  <= '0;
            code <= '0;
            ones <= '0;
            k    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rem  <= din;
                        fhi  <= F93;
                        flo  <= F92;
                        code <= '0;
                        ones <= '0;
                        k    <= 7'd93;
                    end
                end
                RUN: begin
                    if (rem >= fhi) begin
                        code[k - 7'd2] <= 1'b1;
                        rem            <= rem - fhi;
                        ones           <= ones + 7'd1;
                    end
                    fhi <= flo;
                    flo <= fhi - flo;
                    k   <= k - 7'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fib_encoder.sv
// Directed bench for fib_encoder: latency, known codes, ignored starts,
// mid-run reset and back-to-back acceptance with start held high.
module tb_fib_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] din;
    logic        busy;
    logic        done;
    logic [91:0] code;
    logic [6:0]  ones;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] fib [0:91];   // fib[i] = F(i+2)

    fib_encoder dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .code  (code),
        .ones  (ones)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept v, wait (bounded) for done, check latency/result and the N+93 release.
    task automatic encode(input string tag, input logic [63:0] v,
                          input logic [91:0] exp_code, input logic [6:0] exp_ones);
        int lat;
        @(negedge clk);
        start = 1'b1;
        din   = v;
        @(posedge clk); #1;
        start = 1'b0;
        din   = '0;
        chk({tag, "_busy"}, busy, 1'b1);
        lat = 0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (done) begin lat = c; break; end
        end
        chk({tag, "_lat"}, lat, 92);
        chk({tag, "_code"}, code, exp_code);
        chk({tag, "_ones"}, ones, exp_ones);
        @(posedge clk); #1;
        chk({tag, "_done_drop"}, {busy, done}, 2'b00);
    endtask

    initial begin
        logic [63:0] sum;
        int          ndone;

        fib[0] = 64'd1;
        fib[1] = 64'd2;
        for (int i = 2; i < 92; i++) fib[i] = fib[i-1] + fib[i-2];

        // Reset state
        rst = 1'b0; start = 1'b0; din = '0;
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_code", code, 92'd0);
        chk("rst_ones", ones, 7'd0);
        @(negedge clk); rst = 1'b1;

        // Known small values and the top digit
        encode("d0",   64'd0,   92'd0,     7'd0);
        encode("d1",   64'd1,   92'h1,     7'd1);
        encode("d100", 64'd100, 92'h214,   7'd3);
        encode("d12",  64'd12,  92'h15,    7'd3);
        encode("dF93", 64'd12200160415121876738, 92'd1 << 91, 7'd1);

        // All-ones input: check structural properties of the code
        @(negedge clk); start = 1'b1; din = '1;
        @(posedge clk); #1; start = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin @(posedge clk); #1; end
        chk("max_done", done, 1'b1);
        chk("max_top", code[91], 1'b1);
        chk("max_adj", code & (code >> 1), 92'd0);
        sum = '0;
        for (int i = 0; i < 92; i++) if (code[i]) sum = sum + fib[i];
        chk("max_sum", sum, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("max_ones", ones, $countones(code));
        @(posedge clk); #1;

        // Starts during RUN (N+5) and on the final RUN edge (N+92) are ignored
        @(negedge clk); start = 1'b1; din = 64'd100;
        @(posedge clk); #1; start = 1'b0;
        ndone = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            start = (i == 5 || i == 92);
            din   = 64'd7;
            @(posedge clk); #1;
            if (done) ndone++;
            if (i == 92) chk("ign_done92", done, 1'b1);
        end
        start = 1'b0;
        chk("ign_ndone", ndone, 1);
        chk("ign_code", code, 92'h214);
        chk("ign_ones", ones, 7'd3);
        chk("ign_busy", busy, 1'b0);

        // Reset mid-run at N+40 clears everything immediately
        @(negedge clk); start = 1'b1; din = 64'd100;
        @(posedge clk); #1; start = 1'b0;
        repeat (40) begin @(posedge clk); end
        #1 rst = 1'b0;
        #1;
        chk("mrst_all", {busy, done, ones, code}, 101'd0);
        @(negedge clk); rst = 1'b1;
        encode("post_rst", 64'd12, 92'h15, 7'd3);

        // start held high: acceptances at N and N+94 only
        @(negedge clk); start = 1'b1; din = 64'd1;
        @(posedge clk); #1;
        for (int j = 1; j <= 187; j++) begin
            @(negedge clk);
            din = (j == 94) ? 64'd100 : 64'(j + 1000);
            @(posedge clk); #1;
            if (j == 92)  chk("hold_code1", {done, ones, code}, {1'b1, 7'd1, 92'h1});
            if (j == 93)  chk("hold_idle93", {busy, done}, 2'b00);
            if (j == 94)  chk("hold_acc94", busy, 1'b1);
            if (j == 186) chk("hold_code2", {done, ones, code}, {1'b1, 7'd3, 92'h214});
        end
        start = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
